// File: rtl/uart_line_coding_ctrl.sv
// uart_line_coding_ctrl: collects a 7-byte SET_LINE_CODING record, validates it, drains the UART
// transmitter, commits BAUD_RATE/PARITY_BIT/STOP_BIT/DATA_BITS atomically, then holds TX during settle.
// Optional feature: define LC_DRAIN_TIMEOUT_EN to force the commit (with a CFG_ERR pulse) when the
// drain has lasted DRAIN_TIMEOUT cycles with TX_BUSY still high.
module uart_line_coding_ctrl #(
    parameter logic [31:0] DEFAULT_BAUD  = 32'd115200,
    parameter logic [31:0] MIN_BAUD      = 32'd300,
    parameter logic [31:0] MAX_BAUD      = 32'd6000000,
    parameter logic [15:0] SETTLE_CYCLES = 16'd64,
    parameter logic [23:0] DRAIN_TIMEOUT = 24'd6000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LC_START,
    input  logic [7:0]  LC_DATA,
    input  logic        LC_VAL,
    output logic        LC_RDY,
    input  logic [15:0] TX_REQ_DATA,
    input  logic        TX_REQ_VAL,
    output logic        TX_STALL,
    output logic [15:0] TX_DATA,
    output logic        TX_DATA_VAL,
    input  logic        TX_BUSY,
    output logic [31:0] BAUD_RATE,
    output logic [7:0]  PARITY_BIT,
    output logic [7:0]  STOP_BIT,
    output logic [7:0]  DATA_BITS,
    output logic        CFG_BUSY,
    output logic        CFG_ERR
);
    localparam logic [2:0] S_RUN     = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_APPLY   = 3'd3;
    localparam logic [2:0] S_SETTLE  = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [2:0]  idx;
    logic [2:0]  wr_idx;
    logic [7:0]  rec [0:6];
    logic        idle_seen;
    logic [15:0] settle_cnt;
    logic        cfg_err_q;
    logic        cfg_busy;
    logic        tx_open;
    logic        start_acc;
    logic        val_acc;
    logic        wr_en;
    logic        last;
    logic [31:0] rate;
    logic        rate_ok;
    logic        fmt_ok;
    logic        parity_ok;
    logic        bits_ok;
    logic        rec_ok;
    logic        drain_done;
    logic        drain_timeout;
    logic        settle_done;

    assign cfg_busy  = (state == S_DRAIN) | (state == S_APPLY) | (state == S_SETTLE);
    assign tx_open   = ~cfg_busy;
    assign CFG_BUSY  = cfg_busy;
    assign LC_RDY    = ~cfg_busy;
    assign CFG_ERR   = cfg_err_q;

    // A start (possibly with a byte) always begins at index 0; bytes without a start only count in COLLECT.
    assign start_acc = LC_START & ~cfg_busy;
    assign val_acc   = LC_VAL & ~cfg_busy;
    assign wr_en     = val_acc & (start_acc | (state == S_COLLECT));
    assign wr_idx    = start_acc ? 3'd0 : idx;
    assign last      = wr_en & (wr_idx == 3'd6);

    // bDataBits is still on LC_DATA in the validation cycle; the other six bytes are already stored.
    assign rate      = {rec[3], rec[2], rec[1], rec[0]};
    assign rate_ok   = (rate >= MIN_BAUD) & (rate <= MAX_BAUD);
    assign fmt_ok    = rec[4] <= 8'd2;
    assign parity_ok = rec[5] <= 8'd4;
    assign bits_ok   = LC_DATA inside {8'd5, 8'd6, 8'd7, 8'd8, 8'd16};
    assign rec_ok    = rate_ok & fmt_ok & parity_ok & bits_ok;

    // Two idle cycles in a row cover the one-cycle lag between a send and TX_BUSY rising.
    assign drain_done  = (state == S_DRAIN) & ~TX_BUSY & idle_seen;
    assign settle_done = (state == S_SETTLE) & (({1'b0, settle_cnt} + 17'd1) >= {1'b0, SETTLE_CYCLES});

`ifdef LC_DRAIN_TIMEOUT_EN
    logic [23:0] drain_cnt;

    // Count cycles spent in DRAIN so a transmitter held busy cannot block reconfiguration forever.
    always_ff @(posedge CLK) begin
        if (RST || state != S_DRAIN)
            drain_cnt <= 24'd0;
        else
            drain_cnt <= drain_cnt + 24'd1;
    end

    assign drain_timeout = (state == S_DRAIN) & TX_BUSY & (drain_cnt == DRAIN_TIMEOUT - 24'd1);
`else
    logic unused_drain_timeout;

    assign unused_drain_timeout = ^DRAIN_TIMEOUT;
    assign drain_timeout        = 1'b0;
`endif

    // The TX path is only open while no reconfiguration is in flight.
    always_comb begin
        TX_DATA     = TX_REQ_DATA;
        TX_DATA_VAL = tx_open & TX_REQ_VAL & ~TX_BUSY;
        TX_STALL    = tx_open ? TX_BUSY : 1'b1;
    end

    // Next-state selection for the reconfiguration sequence.
    always_comb begin
        state_nx = state;
        case (state)
            S_RUN:     state_nx = start_acc ? S_COLLECT : S_RUN;
            S_COLLECT: state_nx = last ? (rec_ok ? S_DRAIN : S_RUN) : S_COLLECT;
            S_DRAIN:   state_nx = (drain_done | drain_timeout) ? S_APPLY : S_DRAIN;
            S_APPLY:   state_nx = S_SETTLE;
            S_SETTLE:  state_nx = settle_done ? S_RUN : S_SETTLE;
            default:   state_nx = S_RUN;
        endcase
    end

    // State register, byte index and the one-cycle error pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_RUN;
            idx       <= 3'd0;
            cfg_err_q <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= last ? 3'd0 : (wr_en ? wr_idx + 3'd1 : (start_acc ? 3'd0 : idx));
            cfg_err_q <= (last & ~rec_ok) | drain_timeout;
        end
    end

    // Shadow record; the live config is only touched in APPLY.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 7; i++)
                rec[i] <= 8'd0;
        end else if (wr_en) begin
            rec[wr_idx] <= LC_DATA;
        end
    end

    // Remember whether TX_BUSY was low on the previous DRAIN cycle.
    always_ff @(posedge CLK) begin
        if (RST)
            idle_seen <= 1'b0;
        else
            idle_seen <= (state == S_DRAIN) & ~TX_BUSY;
    end

    // Settle counter restarts on every entry to SETTLE and saturates instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RST || state != S_SETTLE)
            settle_cnt <= 16'd0;
        else if (settle_cnt != 16'hFFFF)
            settle_cnt <= settle_cnt + 16'd1;
    end

    // Atomic commit of all four config outputs from the shadow record.
    always_ff @(posedge CLK) begin
        if (RST) begin
            BAUD_RATE  <= DEFAULT_BAUD;
            PARITY_BIT <= 8'd0;
            STOP_BIT   <= 8'd0;
            DATA_BITS  <= 8'd8;
        end else if (state == S_APPLY) begin
            BAUD_RATE  <= rate;
            PARITY_BIT <= rec[5];
            STOP_BIT   <= rec[4];
            DATA_BITS  <= rec[6];
        end
    end
endmodule

// File: doc/uart_line_coding_ctrl.md
Name: uart_line_coding_ctrl

Overview:
- Sequences runtime reconfiguration of the UART core from USB CDC SET_LINE_CODING payloads: collects the 7-byte line-coding record, validates it, drains the transmitter, commits BAUD_RATE/PARITY_BIT/STOP_BIT/DATA_BITS atomically, then holds TX off until the baud divider has settled.
- Sits between the USB class/loopback logic and the UART core.
- Owns the UART TX request path so that no character is launched with a half-updated configuration.

Parameters:
- DEFAULT_BAUD, 32'd115200, BAUD_RATE value after reset.
- MIN_BAUD, 32'd300, lowest accepted dwDTERate.
- MAX_BAUD, 32'd6000000, highest accepted dwDTERate.
- SETTLE_CYCLES, 16'd64, CLK cycles TX is held off after commit; must cover the divider latency.
- DRAIN_TIMEOUT, 24'd6000000, CLK cycles before a stuck drain is forced; used only with the optional feature.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- LC_START  in  1  start of a new SET_LINE_CODING data stage; clears byte index
- LC_DATA  in  8  payload byte
- LC_VAL  in  1  LC_DATA valid; accepted when LC_RDY=1
- LC_RDY  out  1  controller accepts LC_START/LC_VAL
- TX_REQ_DATA  in  16  upstream TX word
- TX_REQ_VAL  in  1  upstream TX request
- TX_STALL  out  1  upstream must hold request
- TX_DATA  out  16  to UART TX_DATA
- TX_DATA_VAL  out  1  to UART TX_DATA_VAL
- TX_BUSY  in  1  from UART TX_BUSY
- BAUD_RATE  out  32  to UART
- PARITY_BIT  out  8  0 none, 1 odd, 2 even, 3 mark, 4 space
- STOP_BIT  out  8  0 = 1 stop bit, 1 = 1.5 stop bits, 2 = 2 stop bits
- DATA_BITS  out  8  5, 6, 7, 8 or 16
- CFG_BUSY  out  1  reconfiguration in progress
- CFG_ERR  out  1  one-cycle pulse: record rejected, or drain forced

Behaviour:
- Reset values:
  - BAUD_RATE=DEFAULT_BAUD, PARITY_BIT=0, STOP_BIT=0, DATA_BITS=8.
  - LC_RDY=1, CFG_BUSY=0, CFG_ERR=0, TX_DATA_VAL=0, TX_STALL=0.
  - State RUN, byte index 0.
- RST mid-operation discards any partial record and restores the reset values, including defaults on the config outputs.
- States: RUN, COLLECT, DRAIN, APPLY, SETTLE.
- RUN:
  - LC_START -> COLLECT with index 0.
  - An LC_VAL without a prior LC_START is ignored.
- COLLECT:
  - Each LC_VAL stores a byte into the shadow record at the current index, then index+1.
  - Byte order: bytes 0-3 dwDTERate little-endian, 4 bCharFormat, 5 bParityType, 6 bDataBits.
  - LC_START restarts at index 0.
  - Simultaneous LC_START and LC_VAL: the byte is stored as index 0 and the index becomes 1.
- Validation, on the cycle byte 6 is accepted (cycle N):
  - Valid when MIN_BAUD <= rate <= MAX_BAUD, bCharFormat <= 2, bParityType <= 4, and bDataBits is one of {5,6,7,8,16}.
  - Valid -> DRAIN at N+1.
  - Invalid -> CFG_ERR=1 at N+1, return to RUN, config outputs unchanged.
- DRAIN:
  - Exits to APPLY once TX_BUSY has been 0 for 2 consecutive cycles. This covers the one-cycle DATA_SEND->BUSY lag.
- APPLY:
  - Single cycle; all four config outputs update together from the shadow record.
  - New values are visible the cycle after APPLY.
- SETTLE:
  - Counter runs SETTLE_CYCLES cycles, then -> RUN.
- CFG_BUSY is 1 in DRAIN, APPLY and SETTLE.
- LC_RDY = ~CFG_BUSY. LC_START and LC_VAL are ignored while LC_RDY=0.
- TX path, combinational:
  - TX_DATA = TX_REQ_DATA.
  - In RUN/COLLECT: TX_DATA_VAL = TX_REQ_VAL & ~TX_BUSY, and TX_STALL = TX_BUSY.
  - In DRAIN/APPLY/SETTLE: TX_DATA_VAL = 0 and TX_STALL = 1.
  - A word is transferred when TX_REQ_VAL & ~TX_STALL.
- The 32-bit rate compare is unsigned. The SETTLE counter is 16 bits and does not wrap.

Optional Feature:
- Macro: LC_DRAIN_TIMEOUT_EN.
- Defined: a 24-bit counter runs in DRAIN. When it reaches DRAIN_TIMEOUT with TX_BUSY still 1 (e.g. CTS held high), the controller forces APPLY and pulses CFG_ERR in that cycle.
- Not defined: DRAIN waits indefinitely and the counter is absent.

Test Plan:
- Reset, then LC_START plus bytes 00 C2 01 00 00 00 08 (115200, 1 stop, no parity, 8 bits) with TX_BUSY=0 -> CFG_BUSY high for 2+1+64 cycles; BAUD_RATE=115200, DATA_BITS=8; CFG_ERR stays 0.
- Bytes 00 E1 00 00 02 01 07 (57600, 2 stop, odd, 7 bits) while TX_BUSY=1 for 40 cycles -> config unchanged until 2 cycles after TX_BUSY falls; then BAUD_RATE=57600, STOP_BIT=2, PARITY_BIT=1, DATA_BITS=7.
- Record with bDataBits=9, and separately a rate of 100 -> CFG_ERR one-cycle pulse, config unchanged, CFG_BUSY never asserted.
- TX_REQ_VAL=1 continuously across a reconfiguration -> TX_DATA_VAL=0 and TX_STALL=1 for the whole DRAIN..SETTLE span; the first word after SETTLE ends is sent with the new config.
- LC_START after 3 bytes, followed by a full 7-byte record -> only the second record is applied. LC_VAL during SETTLE -> ignored.
- With LC_DRAIN_TIMEOUT_EN defined, DRAIN_TIMEOUT=100 and TX_BUSY held at 1 -> APPLY at cycle 100 of DRAIN with a simultaneous CFG_ERR pulse.
